// File: rtl/hdlc_rx_pkg.sv
// Shared types and constants for the HDLC receive deframer.
package hdlc_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SYNC,
        ST_DATA
    } state_t;

    localparam logic [7:0] FLAG       = 8'h7E;
    localparam logic [2:0] STUFF_ONES = 3'd5;
    localparam logic [2:0] ABORT_ONES = 3'd7;

endpackage

// File: rtl/hdlc_rx_linedec.sv
// Raw line decoder: tracks the last received bits and the current run of ones,
// and flags the current strobed bit as flag end, abort or stuffed zero.
module hdlc_rx_linedec
    import hdlc_rx_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    input  logic i_en,
    output logic o_flag,
    output logic o_abort,
    output logic o_stuff
);

    // r_shift[0] is the oldest of the seven previous raw bits
    logic [6:0] r_shift;
    logic [2:0] r_ones;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_ones  <= '0;
        end else if (i_en) begin
            r_shift <= {i_rx, r_shift[6:1]};
            if (!i_rx) begin
                r_ones <= '0;
            end else if (r_ones != ABORT_ONES) begin
                r_ones <= r_ones + 3'd1;
            end
        end
    end

    assign o_flag  = i_en && ({i_rx, r_shift} == FLAG);
    assign o_abort = i_en && i_rx && (r_ones == (ABORT_ONES - 3'd1));
    assign o_stuff = i_en && !i_rx && (r_ones == STUFF_ONES);

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: frame FSM, octet assembly and one-octet pending delay
// so the closing flag's bits are never emitted as data.
module hdlc_rx_deframer
    import hdlc_rx_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_ValidFrame,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ZeroDetect,
    output logic       Rx_EoF,
    output logic       Rx_FrameError
);

    logic w_flag;
    logic w_abort_bit;
    logic w_stuff_bit;

    hdlc_rx_linedec u_linedec (
        .i_clk   (Clk),
        .i_rst_n (Rst),
        .i_rx    (Rx),
        .i_en    (RxEN),
        .o_flag  (w_flag),
        .o_abort (w_abort_bit),
        .o_stuff (w_stuff_bit)
    );

    state_t     r_state,  w_state_nxt;
    logic [2:0] r_bitcnt, w_bitcnt_nxt;
    logic [6:0] r_asm,    w_asm_nxt;
    logic [7:0] r_pend,   w_pend_nxt;
    logic [7:0] r_data,   w_data_nxt;
    logic [7:0] w_octet;
    logic       r_newbyte, w_newbyte;
    logic       r_eof,     w_eof;
    logic       r_ferr,    w_ferr;
    logic       r_abort,   w_abort;
    logic       r_zero,    w_zero;
    logic       r_flagdet;
    logic       r_valid;

    assign w_octet = {Rx, r_asm};

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_asm_nxt    = r_asm;
        w_pend_nxt   = r_pend;
        w_data_nxt   = r_data;
        w_newbyte    = 1'b0;
        w_eof        = 1'b0;
        w_ferr       = 1'b0;
        w_abort      = 1'b0;
        w_zero       = 1'b0;
        if (RxEN) begin
            // A flag wins over an octet completing on the same bit
            if (w_flag) begin
                w_bitcnt_nxt = '0;
                if (r_state == ST_DATA) begin
                    if (r_bitcnt == 3'd7) begin
                        w_newbyte  = 1'b1;
                        w_eof      = 1'b1;
                        w_data_nxt = r_pend;
                    end else begin
                        w_ferr = 1'b1;
                    end
                    w_pend_nxt = '0;
                end
                w_state_nxt = ST_SYNC;
            end else if (r_state != ST_HUNT) begin
                if (w_abort_bit) begin
                    w_abort      = 1'b1;
                    w_pend_nxt   = '0;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = ST_HUNT;
                end else if (w_stuff_bit) begin
                    w_zero = 1'b1;
                end else begin
                    w_asm_nxt    = w_octet[7:1];
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_pend_nxt = w_octet;
                        if (r_state == ST_DATA) begin
                            w_newbyte  = 1'b1;
                            w_data_nxt = r_pend;
                        end
                        w_state_nxt = ST_DATA;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state   <= ST_HUNT;
            r_bitcnt  <= '0;
            r_asm     <= '0;
            r_pend    <= '0;
            r_data    <= '0;
            r_newbyte <= 1'b0;
            r_eof     <= 1'b0;
            r_ferr    <= 1'b0;
            r_abort   <= 1'b0;
            r_zero    <= 1'b0;
            r_flagdet <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_asm     <= w_asm_nxt;
            r_pend    <= w_pend_nxt;
            r_data    <= w_data_nxt;
            r_newbyte <= w_newbyte;
            r_eof     <= w_eof;
            r_ferr    <= w_ferr;
            r_abort   <= w_abort;
            r_zero    <= w_zero;
            r_flagdet <= w_flag;
            r_valid   <= (w_state_nxt == ST_DATA);
        end
    end

    assign Rx_Data        = r_data;
    assign Rx_NewByte     = r_newbyte;
    assign Rx_ValidFrame  = r_valid;
    assign Rx_FlagDetect  = r_flagdet;
    assign Rx_AbortDetect = r_abort;
    assign Rx_ZeroDetect  = r_zero;
    assign Rx_EoF         = r_eof;
    assign Rx_FrameError  = r_ferr;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench: frames are built at octet level with a transmitter-side
// model that predicts each receiver event; a monitor checks events in order.
module tb_hdlc_rx_deframer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx = 1'b0;
    logic       RxEN = 1'b0;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte, Rx_ValidFrame, Rx_FlagDetect, Rx_AbortDetect;
    logic       Rx_ZeroDetect, Rx_EoF, Rx_FrameError;

    hdlc_rx_deframer dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Rx             (Rx),
        .RxEN           (RxEN),
        .Rx_Data        (Rx_Data),
        .Rx_NewByte     (Rx_NewByte),
        .Rx_ValidFrame  (Rx_ValidFrame),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_AbortDetect (Rx_AbortDetect),
        .Rx_ZeroDetect  (Rx_ZeroDetect),
        .Rx_EoF         (Rx_EoF),
        .Rx_FrameError  (Rx_FrameError)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       nb;
        logic [7:0] d;
        logic       eof;
        logic       ferr;
        logic       ab;
        logic       fl;
        logic       zd;
        logic       vf;
    } ev_t;

    ev_t         exp_q[$];
    bit          tx_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_last = 8'h00;
    logic [7:0]  m_oct  = 8'h00;
    logic [7:0]  m_prev = 8'h00;
    int unsigned m_n    = 0;
    int unsigned m_run  = 0;

    task automatic push_ev(input bit nb, input logic [7:0] d, input bit eof, input bit ferr,
                           input bit ab, input bit fl, input bit zd, input bit vf);
        ev_t e;
        if (nb) m_last = d;
        e.nb = nb; e.d = m_last; e.eof = eof; e.ferr = ferr;
        e.ab = ab; e.fl = fl; e.zd = zd; e.vf = vf;
        exp_q.push_back(e);
    endtask

    // Bit after the opening flag: every 8th one completes an octet; the first
    // octet only enters the frame, later ones release the previous octet.
    task automatic tx_payload(input bit b, input bit stuff_ok);
        m_n++;
        m_oct = {b, m_oct[7:1]};
        tx_q.push_back(b);
        if (m_n % 8 == 0) begin
            if (m_n / 8 >= 2) push_ev(1'b1, m_prev, 0, 0, 0, 0, 0, 1);
            m_prev = m_oct;
        end
        if (stuff_ok) begin
            m_run = b ? m_run + 1 : 0;
            if (m_run == 5) begin
                tx_q.push_back(1'b0);
                push_ev(1'b0, 8'h00, 0, 0, 0, 0, 1, (m_n >= 8));
                m_run = 0;
            end
        end
    endtask

    task automatic tx_flag_open();
        tx_q.push_back(1'b0);
        repeat (6) tx_q.push_back(1'b1);
        tx_q.push_back(1'b0);
        push_ev(1'b0, 8'h00, 0, 0, 0, 1, 0, 0);
        m_n = 0; m_run = 0;
    endtask

    task automatic tx_flag_close();
        tx_payload(1'b0, 1'b0);
        repeat (6) tx_payload(1'b1, 1'b0);
        m_n++;
        tx_q.push_back(1'b0);
        if (m_n <= 8)          push_ev(1'b0, 8'h00, 0, 0, 0, 1, 0, 0);
        else if (m_n % 8 == 0) push_ev(1'b1, m_prev, 1, 0, 0, 1, 0, 0);
        else                   push_ev(1'b0, 8'h00, 0, 1, 0, 1, 0, 0);
        m_n = 0; m_run = 0;
    endtask

    task automatic tx_abort();
        while (m_run < 6) begin
            tx_payload(1'b1, 1'b0);
            m_run++;
        end
        tx_q.push_back(1'b1);
        push_ev(1'b0, 8'h00, 0, 0, 1, 0, 0, 0);
        m_n = 0; m_run = 0;
    endtask

    task automatic tx_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) tx_payload(v[i], 1'b1);
    endtask

    task automatic tx_tail(input int unsigned k, input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (i < int'(k)) tx_payload(v[i], 1'b1);
    endtask

    task automatic tx_raw_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) tx_q.push_back(v[i]);
    endtask

    function automatic logic [7:0] rnd_byte();
        case ($urandom_range(0, 3))
            0:       return 8'hFF;
            1:       return 8'h7E;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic drive_all();
        while (tx_q.size() > 0) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge Clk); #1;
                    RxEN = 1'b0;
                    Rx   = 1'($urandom);
                end
            end
            @(posedge Clk); #1;
            RxEN = 1'b1;
            Rx   = tx_q.pop_front();
        end
        @(posedge Clk); #1;
        RxEN = 1'b0;
        repeat (3) @(posedge Clk);
    endtask

    always @(negedge Clk) begin
        ev_t act, e;
        if (Rst && (Rx_NewByte || Rx_EoF || Rx_FrameError || Rx_AbortDetect ||
                    Rx_FlagDetect || Rx_ZeroDetect)) begin
            act = {Rx_NewByte, Rx_Data, Rx_EoF, Rx_FrameError, Rx_AbortDetect,
                   Rx_FlagDetect, Rx_ZeroDetect, Rx_ValidFrame};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got=%h required=none t=%0t", act, $time);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL event got=%h required=%h t=%0t", act, e, $time);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        logic [14:0] v;
        @(negedge Clk);
        v = {Rx_Data, Rx_NewByte, Rx_ValidFrame, Rx_FlagDetect, Rx_AbortDetect,
             Rx_ZeroDetect, Rx_EoF, Rx_FrameError};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s got=%h required=0", name, v);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int unsigned kind, nbytes;

        repeat (3) @(posedge Clk);
        check_all_zero("reset_state");
        @(posedge Clk); #1;
        Rst = 1'b1;

        // Two-octet frame, stuffed 0xFF frame, abort then ignored octet
        tx_flag_open(); tx_byte(8'hA5); tx_byte(8'h3C); tx_flag_close();
        tx_flag_open(); tx_byte(8'hFF); tx_flag_close();
        tx_flag_open(); tx_byte(8'h12); tx_abort(); tx_raw_byte(8'h34);
        // Misaligned close, then three back-to-back flags
        tx_flag_open(); tx_byte(8'h55); tx_tail(3, 8'h05); tx_flag_close();
        tx_flag_open(); tx_flag_close(); tx_flag_open();
        drive_all();

        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            tx_flag_open();
            if (kind < 6) begin
                nbytes = $urandom_range(0, 5);
                repeat (nbytes) tx_byte(rnd_byte());
                tx_flag_close();
            end else if (kind < 8) begin
                nbytes = $urandom_range(1, 3);
                repeat (nbytes) tx_byte(rnd_byte());
                tx_tail($urandom_range(1, 7), rnd_byte());
                tx_flag_close();
            end else begin
                nbytes = $urandom_range(0, 3);
                repeat (nbytes) tx_byte(rnd_byte());
                tx_tail($urandom_range(0, 7), rnd_byte());
                tx_abort();
                tx_raw_byte(rnd_byte() & 8'hDF);
            end
            drive_all();
        end

        // Reset in the middle of a frame with a byte already on Rx_Data
        tx_flag_open(); tx_byte(8'h66); tx_byte(8'h99); tx_byte(8'h42);
        drive_all();
        @(negedge Clk);
        checks++;
        if (Rx_ValidFrame !== 1'b1) begin
            errors++;
            $display("FAIL valid_before_reset got=%b required=1", Rx_ValidFrame);
        end
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk);
        check_all_zero("midframe_reset");
        @(posedge Clk); #1;
        Rst   = 1'b1;
        m_last = 8'h00;
        tx_raw_byte(8'h77); tx_raw_byte(8'h88);
        tx_flag_open(); tx_byte(8'h5A); tx_byte(8'hC3); tx_flag_close();
        drive_all();

        repeat (10) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
